aes_key_schedule_seq: RTL and testbench

//  Iterative AES key schedule; feeds the allKeys bus of the AES encrypt datapath.
//  - Expands an Nk-word cipher key into 4*(Nr+1) words, one word per clock.
//  - Holds the full schedule stable with done high until the next start.
//  - Replaces the combinational expander so only one SubWord sits in the clock path.

---
 rtl/aes_key_schedule_seq_pkg.sv | 38 +++
 rtl/aes_sub_word.sv | 11 +
 rtl/aes_key_schedule_seq.sv | 86 ++++++++
 tb/tb_aes_key_schedule_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/aes_key_schedule_seq_pkg.sv
// rtl/aes_key_schedule_seq_pkg.sv - shared AES helpers: FSM states, S-box table, xtime
package aes_key_schedule_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - combinational SubWord, four parallel S-box lookups
module aes_sub_word
  import aes_key_schedule_seq_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subbed
);

  assign subbed = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/aes_key_schedule_seq.sv
// rtl/aes_key_schedule_seq.sv - iterative AES key expansion, one schedule word per clock
module aes_key_schedule_seq
  import aes_key_schedule_seq_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [Nk*32-1:0]        key,
  output logic [(Nr+1)*128-1:0]   allKeys,
  output logic                    busy,
  output logic                    done
);

  localparam int         NW     = 4 * (Nr + 1);
  localparam logic [5:0] LAST   = 6'(NW - 1);
  localparam logic [5:0] NK_I   = 6'(Nk);
  localparam logic [2:0] J_WRAP = 3'(Nk - 1);

  state_t      state, state_nxt;
  logic [5:0]  i;
  logic [2:0]  j;
  logic [7:0]  rcon;
  logic [31:0] w [NW];
  logic [31:0] temp, prev, sw_in, sw_out, word_new;

  aes_sub_word u_sub_word (
    .word   (sw_in),
    .subbed (sw_out)
  );

  // The single SubWord serves both the j==0 (rotated) and the AES-256 j==4 cases.
  always_comb begin
    temp  = w[i - 6'd1];
    prev  = w[i - NK_I];
    sw_in = (j == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    if (j == 3'd0)
      word_new = prev ^ sw_out ^ {rcon, 24'h0};
    else if (Nk == 8 && j == 3'd4)
      word_new = prev ^ sw_out;
    else
      word_new = prev ^ temp;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_EXPAND;
      ST_EXPAND:        if (i == LAST) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      i     <= '0;
      j     <= '0;
      rcon  <= 8'h01;
      for (int k = 0; k < NW; k++) w[k] <= '0;
    end else begin
      state <= state_nxt;
      if (state != ST_EXPAND && start) begin
        for (int k = 0; k < Nk; k++) w[k] <= key[(Nk-1-k)*32 +: 32];
        i    <= NK_I;
        j    <= '0;
        rcon <= 8'h01;
      end else if (state == ST_EXPAND) begin
        w[i] <= word_new;
        i    <= i + 6'd1;
        j    <= (j == J_WRAP) ? 3'd0 : j + 3'd1;
        if (j == 3'd0) rcon <= xtime(rcon);
      end
    end
  end

  assign busy = (state == ST_EXPAND);
  assign done = (state == ST_DONE);

  for (genvar k = 0; k < NW; k++) begin : g_pack
    assign allKeys[(NW-1-k)*32 +: 32] = w[k];
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb/tb_aes_key_schedule_seq.sv - directed bench for AES-128/192/256 key expansion
module tb_aes_key_schedule_seq;

  logic clk = 1'b0;
  logic reset;
  logic start128, start192, start256;
  logic [127:0]  key128;
  logic [191:0]  key192;
  logic [255:0]  key256;
  logic [1407:0] ak128;
  logic [1663:0] ak192;
  logic [1919:0] ak256;
  logic busy128, busy192, busy256, done128, done192, done256;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           sel;
    int           round;
    logic [127:0] exp;
    string        tag;
  } sb_t;
  sb_t sbq[$];

  always #5 clk = ~clk;

  aes_key_schedule_seq #(.Nk(4), .Nr(10)) dut128 (
    .clk(clk), .reset(reset), .start(start128), .key(key128),
    .allKeys(ak128), .busy(busy128), .done(done128));

  aes_key_schedule_seq #(.Nk(6), .Nr(12)) dut192 (
    .clk(clk), .reset(reset), .start(start192), .key(key192),
    .allKeys(ak192), .busy(busy192), .done(done192));

  aes_key_schedule_seq #(.Nk(8), .Nr(14)) dut256 (
    .clk(clk), .reset(reset), .start(start256), .key(key256),
    .allKeys(ak256), .busy(busy256), .done(done256));

  localparam logic [255:0] KEY_FIPS = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY_SEQ  = 256'h000102030405060708090a0b0c0d0e0f;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rk(input int sel, input int r);
    case (sel)
      0:       return ak128[(10-r)*128 +: 128];
      1:       return ak192[(12-r)*128 +: 128];
      default: return ak256[(14-r)*128 +: 128];
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy128 : (sel == 1) ? busy192 : busy256;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done128 : (sel == 1) ? done192 : done256;
  endfunction

  task automatic drive_start(input int sel, input logic s, input logic [255:0] k);
    case (sel)
      0:       begin start128 = s; key128 = k[127:0]; end
      1:       begin start192 = s; key192 = k[191:0]; end
      default: begin start256 = s; key256 = k; end
    endcase
  endtask

  task automatic push(input int sel, input int r, input logic [127:0] exp, input string tag);
    sb_t e;
    e.sel = sel; e.round = r; e.exp = exp; e.tag = tag;
    sbq.push_back(e);
  endtask

  // Start edge is edge 1; done must first be seen after edge exp_lat.
  task automatic run(input int sel, input logic [255:0] k, input int exp_lat,
                     input int repulse_at, input string tag);
    int n;
    sb_t e;
    drive_start(sel, 1'b1, k);
    @(negedge clk);
    drive_start(sel, 1'b0, k);
    n = 1;
    check({tag, "_busy_rise"}, 128'(get_busy(sel)), 128'd1);
    check({tag, "_done_fall"}, 128'(get_done(sel)), 128'd0);
    while (!get_done(sel) && n < 200) begin
      if (n == repulse_at) drive_start(sel, 1'b1, ~k);
      else                 drive_start(sel, 1'b0, k);
      @(negedge clk);
      n++;
    end
    drive_start(sel, 1'b0, k);
    check({tag, "_latency"}, 128'(n), 128'(exp_lat));
    check({tag, "_busy_low"}, 128'(get_busy(sel)), 128'd0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, rk(e.sel, e.round), e.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive_start(0, 1'b0, '0);
    drive_start(1, 1'b0, '0);
    drive_start(2, 1'b0, '0);
    repeat (2) @(negedge clk);
    check("rst_busy128", 128'(busy128), 128'd0);
    check("rst_done128", 128'(done128), 128'd0);
    check("rst_ak128_zero", 128'(ak128 == '0), 128'd1);
    check("rst_busy256", 128'(busy256), 128'd0);
    check("rst_done192", 128'(done192), 128'd0);
    check("rst_ak256_zero", 128'(ak256 == '0), 128'd1);

    // start together with reset: reset wins
    drive_start(0, 1'b1, KEY_FIPS);
    @(negedge clk);
    reset = 1'b0;
    drive_start(0, 1'b0, KEY_FIPS);
    check("rst_beats_start_busy", 128'(busy128), 128'd0);
    @(negedge clk);
    check("rst_beats_start_idle", 128'(busy128), 128'd0);

    // AES-128 FIPS-197 key
    push(0, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "k128_r0");
    push(0, 1,  128'ha0fafe1788542cb123a339392a6c7605, "k128_r1");
    push(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "k128_r10");
    run(0, KEY_FIPS, 41, 0, "aes128");
    repeat (3) @(negedge clk);
    check("hold_done", 128'(done128), 128'd1);
    check("hold_r10", rk(0, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // restart from DONE with a new key; re-pulse in EXPAND is ignored
    push(0, 0,  128'h000102030405060708090a0b0c0d0e0f, "seq128_r0");
    push(0, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "seq128_r1");
    push(0, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "seq128_r10");
    run(0, KEY_SEQ, 41, 10, "restart128");

    // abort with reset at cycle 20 of an expansion
    drive_start(0, 1'b1, KEY_FIPS);
    @(negedge clk);
    drive_start(0, 1'b0, KEY_FIPS);
    repeat (19) @(negedge clk);
    check("abort_busy_before", 128'(busy128), 128'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 128'(busy128), 128'd0);
    check("abort_done", 128'(done128), 128'd0);
    check("abort_ak_zero", 128'(ak128 == '0), 128'd1);
    reset = 1'b0;
    @(negedge clk);
    push(0, 1,  128'ha0fafe1788542cb123a339392a6c7605, "post_abort_r1");
    push(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_abort_r10");
    run(0, KEY_FIPS, 41, 0, "post_abort");

    // AES-192
    push(1, 0,  128'h000102030405060708090a0b0c0d0e0f, "k192_r0");
    push(1, 12, 128'ha4970a331a78dc09c418c271e3a41d5d, "k192_r12");
    run(1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617, 47, 0, "aes192");

    // AES-256
    push(2, 0,  128'h000102030405060708090a0b0c0d0e0f, "k256_r0");
    push(2, 1,  128'h101112131415161718191a1b1c1d1e1f, "k256_r1");
    push(2, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "k256_r14");
    run(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 53, 0, "aes256");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
